// File: rtl/yin_pkg.sv
// Shared definitions for the YIN tau search: FSM states and percent scaling.
// The DESCEND state exists only when YIN_TAU_LOCAL_MIN_EN is defined.
package yin_pkg;

  localparam int PCT_SCALE = 100;
  localparam int PCT_MAX   = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREP    = 3'd1,
    ST_SCAN    = 3'd2,
`ifdef YIN_TAU_LOCAL_MIN_EN
    ST_DESCEND = 3'd3,
`endif
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/yin_scaled_cmp.sv
// Combinational full-width test a*PCT_SCALE < b.
// The internal width is wide enough that neither operand can overflow.
module yin_scaled_cmp
  import yin_pkg::*;
#(
  parameter int A_WIDTH = 64,
  parameter int B_WIDTH = 71
) (
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic               lt_o
);

  // Seven extra bits hold a*100 because 100 < 2**7.
  localparam int W = (A_WIDTH + 7 > B_WIDTH) ? A_WIDTH + 7 : B_WIDTH;

  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] a_scaled;

  assign a_ext    = W'(a_i);
  assign b_ext    = W'(b_i);
  assign a_scaled = a_ext * W'(PCT_SCALE);
  assign lt_o     = a_scaled < b_ext;

endmodule

// File: rtl/yin_tau_search.sv
// YIN tau search: finds the first d'(tau) below average*pct/100, else the global minimum.
// Defining YIN_TAU_LOCAL_MIN_EN adds a DESCEND phase that follows the dip to its local minimum.
module yin_tau_search
  import yin_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_TAU    = 40,
  parameter int TAU_BITS   = 8,
  parameter int PCT_BITS   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] average,
  input  logic [PCT_BITS-1:0]   thresh_pct,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic [TAU_BITS-1:0]   min_tau,
  output logic [DATA_WIDTH-1:0] min_value,
  output logic                  found
);

  localparam int PW = DATA_WIDTH + PCT_BITS;
  localparam logic [TAU_BITS-1:0] LAST_TAU = TAU_BITS'(MAX_TAU - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic [PCT_BITS-1:0]   pct_q, pct_d;
  logic [PW-1:0]         thr_q, thr_d;
  logic [TAU_BITS-1:0]   tau_q, tau_d;
  logic [TAU_BITS-1:0]   best_tau_q, best_tau_d;
  logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic                  hit_q, hit_d;
  logic [TAU_BITS-1:0]   gmin_tau_q, gmin_tau_d;
  logic [DATA_WIDTH-1:0] gmin_val_q, gmin_val_d;
  logic [TAU_BITS-1:0]   min_tau_q, min_tau_d;
  logic [DATA_WIDTH-1:0] min_value_q, min_value_d;
  logic                  found_q, found_d;

  logic below;
  logic accept;
  logic last_beat;

  yin_scaled_cmp #(
    .A_WIDTH(DATA_WIDTH),
    .B_WIDTH(PW)
  ) u_cmp (
    .a_i (in_data),
    .b_i (thr_q),
    .lt_o(below)
  );

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_SCAN:    in_ready = 1'b1;
`ifdef YIN_TAU_LOCAL_MIN_EN
      ST_DESCEND: in_ready = 1'b1;
`endif
      ST_DRAIN:   in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign last_beat = accept && (tau_q == LAST_TAU);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign min_tau   = min_tau_q;
  assign min_value = min_value_q;
  assign found     = found_q;

  always_comb begin
    state_d     = state_q;
    avg_d       = avg_q;
    pct_d       = pct_q;
    thr_d       = thr_q;
    tau_d       = tau_q;
    best_tau_d  = best_tau_q;
    best_val_d  = best_val_q;
    hit_d       = hit_q;
    gmin_tau_d  = gmin_tau_q;
    gmin_val_d  = gmin_val_q;
    min_tau_d   = min_tau_q;
    min_value_d = min_value_q;
    found_d     = found_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          avg_d      = average;
          pct_d      = (thresh_pct > PCT_BITS'(PCT_MAX)) ? PCT_BITS'(PCT_MAX) : thresh_pct;
          tau_d      = '0;
          hit_d      = 1'b0;
          best_tau_d = '0;
          best_val_d = '0;
          // An all-ones seed with tau 1 still yields the earliest tau if every beat is all-ones.
          gmin_tau_d = TAU_BITS'(1);
          gmin_val_d = '1;
          state_d    = ST_PREP;
        end
      end
      ST_PREP: begin
        thr_d   = PW'(avg_q) * PW'(pct_q);
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (accept) begin
          tau_d = tau_q + TAU_BITS'(1);
          if (tau_q != '0) begin
            if (in_data < gmin_val_q) begin
              gmin_tau_d = tau_q;
              gmin_val_d = in_data;
            end
            if (below) begin
              best_tau_d = tau_q;
              best_val_d = in_data;
              hit_d      = 1'b1;
`ifdef YIN_TAU_LOCAL_MIN_EN
              state_d    = ST_DESCEND;
`else
              state_d    = ST_DRAIN;
`endif
            end
          end
          if (last_beat) state_d = ST_DONE;
        end
      end
`ifdef YIN_TAU_LOCAL_MIN_EN
      ST_DESCEND: begin
        if (accept) begin
          tau_d = tau_q + TAU_BITS'(1);
          if (in_data < best_val_q) begin
            best_tau_d = tau_q;
            best_val_d = in_data;
          end else begin
            state_d = ST_DRAIN;
          end
          if (last_beat) state_d = ST_DONE;
        end
      end
`endif
      ST_DRAIN: begin
        if (accept) begin
          tau_d = tau_q + TAU_BITS'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Results are published on the final beat so they include that beat's effect.
    if (last_beat) begin
      found_d     = hit_d;
      min_tau_d   = hit_d ? best_tau_d : gmin_tau_d;
      min_value_d = hit_d ? best_val_d : gmin_val_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      avg_q       <= '0;
      pct_q       <= '0;
      thr_q       <= '0;
      tau_q       <= '0;
      best_tau_q  <= '0;
      best_val_q  <= '0;
      hit_q       <= 1'b0;
      gmin_tau_q  <= '0;
      gmin_val_q  <= '0;
      min_tau_q   <= '0;
      min_value_q <= '0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      avg_q       <= avg_d;
      pct_q       <= pct_d;
      thr_q       <= thr_d;
      tau_q       <= tau_d;
      best_tau_q  <= best_tau_d;
      best_val_q  <= best_val_d;
      hit_q       <= hit_d;
      gmin_tau_q  <= gmin_tau_d;
      gmin_val_q  <= gmin_val_d;
      min_tau_q   <= min_tau_d;
      min_value_q <= min_value_d;
      found_q     <= found_d;
    end
  end

endmodule

// File: tb/tb_yin_tau_search.sv
// Scoreboard bench for yin_tau_search; expected results come from a plain-arithmetic model.
// Honours YIN_TAU_LOCAL_MIN_EN the same way as the design.
module tb_yin_tau_search;

  localparam int NT = 40;

  typedef struct packed {
    logic [7:0]  tau;
    logic [63:0] value;
    logic        fnd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] average = '0;
  logic [6:0]  thresh_pct = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, busy, done, found;
  logic [7:0]  min_tau;
  logic [63:0] min_value;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [63:0] d_arr[NT];
  logic prev_done = 1'b0;

  yin_tau_search dut (
    .clk(clk), .reset(rst_n), .start(start), .average(average),
    .thresh_pct(thresh_pct), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .min_tau(min_tau),
    .min_value(min_value), .found(found)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: first sub-threshold tau (optionally walked down its dip), else earliest global minimum.
  function automatic exp_t model(input logic [63:0] avg, input int pct);
    logic [127:0] thr;
    int p, first, best;
    exp_t r;
    p = (pct > 100) ? 100 : pct;
    thr = 128'(avg) * 128'(p);
    first = -1;
    for (int k = 1; k < NT; k++)
      if (first < 0 && 128'(d_arr[k]) * 128'(100) < thr) first = k;
    if (first >= 0) begin
      best = first;
`ifdef YIN_TAU_LOCAL_MIN_EN
      while (best + 1 < NT && d_arr[best+1] < d_arr[best]) best++;
`endif
      r.fnd = 1'b1;
    end else begin
      best = 1;
      for (int k = 2; k < NT; k++)
        if (d_arr[k] < d_arr[best]) best = k;
      r.fnd = 1'b0;
    end
    r.tau = 8'(best);
    r.value = d_arr[best];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      check("done_width", {127'd0, prev_done}, 128'd0);
      if (sb_q.size() == 0) begin
        check("done_unexpected", 128'd1, 128'd0);
      end else begin
        e = sb_q.pop_front();
        check("min_tau", 128'(min_tau), 128'(e.tau));
        check("min_value", 128'(min_value), 128'(e.value));
        check("found", 128'(found), 128'(e.fnd));
      end
    end
    prev_done <= rst_n && done;
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_found"}, 128'(found), 128'd0);
    check({tag, "_min_tau"}, 128'(min_tau), 128'd0);
    check({tag, "_min_value"}, 128'(min_value), 128'd0);
  endtask

  // gap_mode: 0 gapless, 1 random, 2 alternating. spur pulses start while busy.
  task automatic do_search(input logic [63:0] avg, input int pct, input int gap_mode,
                           input bit spur, input bit abort);
    int k, cyc;
    bit acc;
    exp_t e;
    e = model(avg, pct);
    @(posedge clk); #1;
    start = 1'b1; average = avg; thresh_pct = 7'(pct);
    if (!abort) sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < NT && cyc < 2000) begin
      if (abort && k == 20) begin
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check_reset_state("abort");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 128'(done), 128'd0);
        return;
      end
      case (gap_mode)
        1:       in_valid = 1'($urandom_range(0, 1));
        2:       in_valid = ~cyc[0];
        default: in_valid = 1'b1;
      endcase
      in_data = d_arr[k];
      start = spur && (cyc == 3 || cyc == 25);
      average = start ? ~avg : avg;
      thresh_pct = start ? 7'd0 : 7'(pct);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (k < NT) begin
      check("beat_timeout", 128'(k), 128'(NT));
      return;
    end
    if (gap_mode == 0) check("scan_cycles", 128'(cyc), 128'(NT + 1));
    @(negedge clk);
    check("done_latency", 128'(done), 128'd1);
    @(negedge clk);
    check("busy_after_done", 128'(busy), 128'd0);
    repeat (3) @(negedge clk);
    check("hold_min_tau", 128'(min_tau), 128'(e.tau));
    check("hold_found", 128'(found), 128'(e.fnd));
    $display("search avg=%0h pct=%0d gap=%0d -> tau=%0d value=%0h found=%0b",
             avg, pct, gap_mode, e.tau, e.value, e.fnd);
  endtask

  task automatic load_scen1();
    for (int k = 0; k < NT; k++) d_arr[k] = 64'd200;
    d_arr[0] = 64'd1; d_arr[1] = 64'd500; d_arr[2] = 64'd90;
    d_arr[3] = 64'd80; d_arr[4] = 64'd70; d_arr[5] = 64'd200;
  endtask

  initial begin
    #1;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    load_scen1();
    do_search(64'd1000, 10, 0, 1'b0, 1'b0);

    for (int k = 0; k < NT; k++) d_arr[k] = 64'd500;
    do_search(64'd1000, 10, 0, 1'b0, 1'b0);

    for (int k = 0; k < NT; k++) d_arr[k] = 64'd100;
    d_arr[3] = 64'd99;
    do_search(64'd100, 127, 0, 1'b0, 1'b0);

    load_scen1();
    do_search(64'd1000, 10, 2, 1'b0, 1'b0);

    do_search(64'd1000, 10, 0, 1'b0, 1'b1);
    check_reset_state("post_abort");
    load_scen1();
    do_search(64'd1000, 10, 0, 1'b1, 1'b0);

    for (int t = 0; t < 16; t++) begin
      logic [63:0] avg;
      avg = {$urandom, $urandom} >> $urandom_range(0, 60);
      for (int k = 0; k < NT; k++)
        d_arr[k] = {$urandom, $urandom} >> $urandom_range(0, 63);
      d_arr[0] = 64'd0;
      if (t % 4 == 0) d_arr[7] = d_arr[12];
      do_search(avg, int'($urandom_range(0, 127)), t % 3, t[0], 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/yin_tau_search.md
YIN_TAU_SEARCH -- requirements
Module: yin_tau_search

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning width of d'(tau) and average values.
REQ-002 SHALL have parameter MAX_TAU, default 40, meaning number of d' beats per search (tau 0..MAX_TAU-1).
REQ-003 SHALL have parameter TAU_BITS, default 8, meaning width of tau outputs; it must satisfy 2**TAU_BITS >= MAX_TAU.
REQ-004 SHALL have parameter PCT_BITS, default 7, meaning width of the threshold-percent input.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that begins a search.
REQ-008 SHALL have port average, input, DATA_WIDTH bits: mean of d', sampled at start.
REQ-009 SHALL have port thresh_pct, input, PCT_BITS bits: threshold in percent of average, sampled at start.
REQ-010 SHALL have port in_valid, input, 1 bit: a d' beat is present.
REQ-011 SHALL have port in_data, input, DATA_WIDTH bits: d'(tau) for the next tau, in ascending tau order.
REQ-012 SHALL have port in_ready, output, 1 bit: the beat is accepted when in_valid and in_ready are both 1.
REQ-013 SHALL have port busy, output, 1 bit: high from the cycle after start until done.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse; results are valid while it is high.
REQ-015 SHALL have port min_tau, output, TAU_BITS bits: the selected tau.
REQ-016 SHALL have port min_value, output, DATA_WIDTH bits: d' at min_tau.
REQ-017 SHALL have port found, output, 1 bit: 1 if min_tau met the threshold, 0 if it is the fallback.

Function
REQ-018 SHALL implement states IDLE -> PREP -> SCAN -> (DESCEND) -> DRAIN -> DONE -> IDLE.
REQ-019 IDLE: on start, SHALL latch average and clamp thresh_pct to 100, then go to PREP; start in any other state SHALL be ignored.
REQ-020 PREP (1 cycle): SHALL register thr_prod = average*pct using DATA_WIDTH+PCT_BITS bits, with no truncation; in_ready=0.
REQ-021 SCAN/DESCEND/DRAIN: in_ready SHALL be 1; the tau counter SHALL advance by 1 per accepted beat, starting at 0.
REQ-022 The tau 0 beat SHALL be consumed but excluded from every comparison, since d'(0)=1 by definition.
REQ-023 SHALL treat a beat as below threshold iff in_data*100 < thr_prod, computed at full width.
REQ-024 SHALL track the running global minimum over tau>=1 using strict <, so the earliest tau wins ties.
REQ-025 In SCAN, the first below-threshold beat SHALL record tau/value as best, set found=1, and go to DESCEND (macro on) or DRAIN (macro off).
REQ-026 In DRAIN, SHALL accept and discard beats until the beat tau=MAX_TAU-1 has been accepted.
REQ-027 Acceptance of beat MAX_TAU-1 in any state SHALL go to DONE on the next edge; done SHALL pulse for exactly 1 cycle, then the FSM returns to IDLE.
REQ-028 If no beat is below threshold, results SHALL be the global-minimum tau/value with found=0.
REQ-029 min_tau, min_value and found SHALL hold their values until the next start.
REQ-030 Gaps in in_valid SHALL stall the scan without losing state.
REQ-031 Latency SHALL be done = 1 cycle after the final beat is accepted; a full search SHALL take 1+1+MAX_TAU+1 cycles when there are no gaps.

Reset
REQ-032 Asserting reset low SHALL immediately force: state IDLE; in_ready, busy, done, found = 0; min_tau, min_value = 0; tau counter = 0.
REQ-033 Reset mid-search SHALL abandon the search with no done pulse; the next start SHALL begin cleanly.

Configuration
REQ-034 With YIN_TAU_LOCAL_MIN_EN defined, DESCEND SHALL behave as follows:
- while the next beat < best, update best;
- on the first beat >= best, go to DRAIN;
- reaching MAX_TAU-1 in DESCEND SHALL report best.
REQ-035 Without YIN_TAU_LOCAL_MIN_EN, the DESCEND state and its logic SHALL be absent, and the first below-threshold tau SHALL be reported.

Structure
REQ-036 Package yin_pkg SHALL hold the state enum, PCT_SCALE=100, and PCT_MAX=100.
REQ-037 Sub-module yin_scaled_cmp SHALL perform the full-width compare (a*PCT_SCALE < b); it is purely combinational.

Verification
REQ-038 Scenario: average=1000, pct=10, d'=[1,500,90,80,70,200,...], MAX_TAU=40 -> macro off: min_tau=2, value=90, found=1; macro on: min_tau=4, value=70.
REQ-039 Scenario: all d'=500, pct=10 -> found=0, min_tau=1, value=500 (earliest tie).
REQ-040 Scenario: pct=127 is clamped to 100; average=100, d'(3)=99 with all others 100 -> min_tau=3, found=1.
REQ-041 Scenario: in_valid toggles 1,0,1,0 -> same result as the gapless run; done occurs exactly 1 cycle after the 40th accepted beat.
REQ-042 Scenario: reset low at beat 20, then a new start -> no done from the first search; the second search is correct; start pulses during busy are ignored.
